// File: rtl/sync_trigger_fsm.sv
// Synchronised gate-to-trigger sequencer.
// A rising edge on the asynchronous fast-gate strobe arms a programmable
// delay. After the delay, a trigger pulse of PULSE_W cycles is driven on the
// channels that were enabled at the arming edge. A hold-off period follows,
// and the block waits for the detectors to report ready again before it
// re-arms.
module sync_trigger_fsm #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 24,
    parameter int PULSE_W = 8,
    parameter int HOLDOFF = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_signal,
    input  logic              fg_signal,
    input  logic [N_CH-1:0]   ch_enable,
    input  logic [N_CH-1:0]   det_ready,
    input  logic [CNT_W-1:0]  delay_cycles,
    output logic [N_CH-1:0]   output_trigger,
    output logic              busy,
    output logic              missed_gate,
    output logic [15:0]       trig_count
);

    // One timer serves both the pulse length and the hold-off wait,
    // so it is sized for the longer of the two.
    localparam int TMR_MAX = (PULSE_W > HOLDOFF) ? PULSE_W : HOLDOFF;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        FIRE,
        HOLD
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              start_s1;
    logic              start_s2;
    logic              fg_s1;
    logic              fg_s2;
    logic              fg_s3;
    logic [2:0]        fg_valid;
    logic [N_CH-1:0]   ready_s1;
    logic [N_CH-1:0]   ready_s2;

    logic [CNT_W-1:0]  delay_cnt;
    logic [CNT_W-1:0]  next_delay_cnt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  next_timer;
    logic [N_CH-1:0]   mask_q;
    logic [N_CH-1:0]   next_mask;
    logic              missed_next;
    logic              fire_entry;

    logic              gate_edge;
    logic              accept_ok;
    logic              latched_ready;

    // Synchronisers for the asynchronous inputs. fg_valid marks when the
    // third fg flop holds a real post-reset sample, so a strobe that is
    // already high when reset releases does not look like a fresh edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            fg_s1    <= 1'b0;
            fg_s2    <= 1'b0;
            fg_s3    <= 1'b0;
            fg_valid <= '0;
            ready_s1 <= '0;
            ready_s2 <= '0;
        end else begin
            start_s1 <= start_signal;
            start_s2 <= start_s1;
            fg_s1    <= fg_signal;
            fg_s2    <= fg_s1;
            fg_s3    <= fg_s2;
            fg_valid <= {fg_valid[1:0], 1'b1};
            ready_s1 <= det_ready;
            ready_s2 <= ready_s1;
        end
    end

    assign gate_edge     = fg_s2 & ~fg_s3 & fg_valid[2];
    assign accept_ok     = (|ch_enable) && ((ready_s2 & ch_enable) == ch_enable);
    assign latched_ready = ((ready_s2 & mask_q) == mask_q);
    assign busy          = (state != IDLE) && (state != ARMED);

    // Next-state logic, counter updates and rejected-gate detection.
    always_comb begin
        next_state     = state;
        next_delay_cnt = delay_cnt;
        next_timer     = timer;
        next_mask      = mask_q;
        missed_next    = 1'b0;
        fire_entry     = 1'b0;
        case (state)
            IDLE: begin
                if (start_s2) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (!start_s2) begin
                    next_state = IDLE;
                end else if (gate_edge) begin
                    if (accept_ok) begin
                        next_mask      = ch_enable;
                        next_delay_cnt = delay_cycles;
                        next_state     = DELAY;
                    end else begin
                        missed_next = 1'b1;
                    end
                end
            end
            DELAY: begin
                missed_next = gate_edge;
                if (!start_s2) begin
                    next_state = IDLE;
                end else if (delay_cnt == '0) begin
                    next_state = FIRE;
                    next_timer = TMR_W'(PULSE_W - 1);
                    fire_entry = 1'b1;
                end else begin
                    next_delay_cnt = delay_cnt - CNT_W'(1);
                end
            end
            FIRE: begin
                missed_next = gate_edge;
                if (timer == '0) begin
                    next_state = HOLD;
                    next_timer = TMR_W'(HOLDOFF - 1);
                end else begin
                    next_timer = timer - TMR_W'(1);
                end
            end
            HOLD: begin
                missed_next = gate_edge;
                if (timer != '0) begin
                    next_timer = timer - TMR_W'(1);
                end else if (latched_ready) begin
                    next_state = start_s2 ? ARMED : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counters, registered outputs and the saturating trigger count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            delay_cnt      <= '0;
            timer          <= '0;
            mask_q         <= '0;
            output_trigger <= '0;
            missed_gate    <= 1'b0;
            trig_count     <= '0;
        end else begin
            state          <= next_state;
            delay_cnt      <= next_delay_cnt;
            timer          <= next_timer;
            mask_q         <= next_mask;
            output_trigger <= (next_state == FIRE) ? next_mask : '0;
            missed_gate    <= missed_next;
            if (fire_entry && (trig_count != 16'hFFFF)) begin
                trig_count <= trig_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sync_trigger_fsm.sv
// Self-checking bench for sync_trigger_fsm: directed scenarios followed by
// randomized stimulus, all compared against a timestamp-based reference model.
module tb_sync_trigger_fsm;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 24;
    localparam int PULSE_W = 8;
    localparam int HOLDOFF = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start_signal = 1'b0;
    logic              fg_signal = 1'b0;
    logic [N_CH-1:0]   ch_enable = '0;
    logic [N_CH-1:0]   det_ready = '0;
    logic [CNT_W-1:0]  delay_cycles = '0;
    logic [N_CH-1:0]   output_trigger;
    logic              busy;
    logic              missed_gate;
    logic [15:0]       trig_count;

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    sync_trigger_fsm #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PULSE_W(PULSE_W), .HOLDOFF(HOLDOFF)
    ) dut (
        .clock(clock), .reset(reset), .start_signal(start_signal),
        .fg_signal(fg_signal), .ch_enable(ch_enable), .det_ready(det_ready),
        .delay_cycles(delay_cycles), .output_trigger(output_trigger),
        .busy(busy), .missed_gate(missed_gate), .trig_count(trig_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: edges are numbered from reset release. A cycle is
    // described by its arming edge and the edge its pulse starts on.
    int              k;
    logic            fg_p1, fg_p2, fg_p3;
    logic            st_p1, st_p2;
    logic [N_CH-1:0] rd_p1, rd_p2;
    int              t_arm;
    int              t_fire;
    bit              armed;
    logic [N_CH-1:0] m_mask;
    int              m_count;
    logic [N_CH-1:0] exp_trig;
    bit              exp_busy;
    bit              exp_missed;

    // Observations taken from the DUT outputs for the directed checks.
    logic [N_CH-1:0] prev_trig;
    int              rise_k;
    int              last_width;
    int              trig_pulses = 0;
    int              miss_pulses = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic modelReset();
        k = 0;
        fg_p1 = 1'b1; fg_p2 = 1'b1; fg_p3 = 1'b1;
        st_p1 = 1'b0; st_p2 = 1'b0;
        rd_p1 = '0;   rd_p2 = '0;
        t_arm = -1; t_fire = 0; armed = 1'b0;
        m_mask = '0; m_count = 0;
        exp_trig = '0; exp_busy = 1'b0; exp_missed = 1'b0;
        prev_trig = '0;
    endtask

    task automatic modelStep();
        logic            st;
        logic            ge;
        logic [N_CH-1:0] rdy;
        k++;
        st  = st_p2;
        ge  = fg_p2 & ~fg_p3;
        rdy = rd_p2;
        exp_missed = 1'b0;
        if (t_arm < 0) begin
            if (!armed) begin
                armed = st;
            end else if (!st) begin
                armed = 1'b0;
            end else if (ge) begin
                if (ch_enable != 0 && (rdy & ch_enable) == ch_enable) begin
                    t_arm  = k;
                    m_mask = ch_enable;
                    t_fire = k + 1 + int'(delay_cycles);
                end else begin
                    exp_missed = 1'b1;
                end
            end
        end else begin
            exp_missed = ge;
            if (k <= t_fire) begin
                if (!st) begin
                    t_arm = -1;
                    armed = 1'b0;
                end else if (k == t_fire && m_count < 65535) begin
                    m_count++;
                end
            end else if (k >= t_fire + PULSE_W + HOLDOFF && (rdy & m_mask) == m_mask) begin
                t_arm = -1;
                armed = st;
            end
        end
        exp_busy = (t_arm >= 0);
        exp_trig = (t_arm >= 0 && k >= t_fire && k < t_fire + PULSE_W) ? m_mask : '0;
        fg_p3 = fg_p2; fg_p2 = fg_p1; fg_p1 = fg_signal;
        st_p2 = st_p1; st_p1 = start_signal;
        rd_p2 = rd_p1; rd_p1 = det_ready;
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
        checkOutput("trig",   32'(output_trigger), 32'(exp_trig));
        checkOutput("busy",   32'(busy),           32'(exp_busy));
        checkOutput("missed", 32'(missed_gate),    32'(exp_missed));
        checkOutput("count",  32'(trig_count),     32'(m_count));
        if (output_trigger != 0 && prev_trig == 0) rise_k = k;
        if (output_trigger == 0 && prev_trig != 0) begin
            last_width = k - rise_k;
            trig_pulses++;
        end
        if (missed_gate) miss_pulses++;
        prev_trig = output_trigger;
    endtask

    task automatic applyStimulus(input logic st, input logic fg, input logic [N_CH-1:0] en,
                                 input logic [N_CH-1:0] rdy, input int dly, input int n);
        start_signal = st;
        fg_signal    = fg;
        ch_enable    = en;
        det_ready    = rdy;
        delay_cycles = CNT_W'(dly);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_trig",  32'(output_trigger), 32'd0);
        checkOutput("rst_busy",  32'(busy),           32'd0);
        checkOutput("rst_miss",  32'(missed_gate),    32'd0);
        checkOutput("rst_count", 32'(trig_count),     32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        modelReset();
    endtask

    int fg_k;
    int base_miss;
    int base_pulses;

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        modelReset();
        doReset();

        // Basic trigger: mask 0101, delay 10, pulse from edge 14 for 8 cycles.
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 10, 5);
        fg_k = k + 1;
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'hF, 10, 30);
        checkOutput("basic_rise",  32'(rise_k - fg_k), 32'd13);
        checkOutput("basic_width", 32'(last_width),    32'd8);
        checkOutput("basic_count", 32'(trig_count),    32'd1);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 10, 30);

        // Enabled channel not ready: gate rejected, stays armed.
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'b1011, 10, 5);
        base_miss = miss_pulses;
        base_pulses = trig_pulses;
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'b1011, 10, 6);
        checkOutput("notready_miss",  32'(miss_pulses - base_miss), 32'd1);
        checkOutput("notready_busy",  32'(busy),                    32'd0);
        checkOutput("notready_count", 32'(trig_count),              32'd1);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 10, 5);

        // Second gate edge during the delay is rejected.
        base_miss = miss_pulses;
        base_pulses = trig_pulses;
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'hF, 10, 2);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 10, 3);
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'hF, 10, 30);
        checkOutput("double_miss",   32'(miss_pulses - base_miss),   32'd1);
        checkOutput("double_pulses", 32'(trig_pulses - base_pulses), 32'd1);
        checkOutput("double_width",  32'(last_width),                32'd8);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 10, 30);

        // Start dropped in the delay aborts the cycle.
        base_pulses = trig_pulses;
        applyStimulus(1'b1, 1'b1, 4'b0011, 4'hF, 10, 5);
        applyStimulus(1'b0, 1'b1, 4'b0011, 4'hF, 10, 20);
        checkOutput("abort_busy",   32'(busy),                       32'd0);
        checkOutput("abort_count",  32'(trig_count),                 32'd2);
        checkOutput("abort_pulses", 32'(trig_pulses - base_pulses),  32'd0);
        applyStimulus(1'b1, 1'b0, 4'b0011, 4'hF, 10, 5);

        // Detector busy for a long time after the trigger holds off re-arm.
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'hF, 10, 14);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'b0000, 10, 6400);
        checkOutput("longhold_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 10, 4);
        checkOutput("longhold_rearm", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'hF, 10, 3);
        checkOutput("longhold_accept", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 10, 30);
        checkOutput("longhold_count", 32'(trig_count), 32'd4);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 10, 5);

        // Reset in the middle of a pulse, with the gate still high afterwards.
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'hF, 10, 15);
        checkOutput("midpulse_trig", 32'(output_trigger), 32'h5);
        doReset();
        base_pulses = trig_pulses;
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'hF, 3, 30);
        checkOutput("stale_gate_count", 32'(trig_count), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'hF, 3, 3);
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'hF, 3, 30);
        checkOutput("fresh_gate_count", 32'(trig_count), 32'd1);

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            start_signal = ($urandom_range(0, 59) != 0) ? 1'b1 : (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 5) == 0) fg_signal = ~fg_signal;
            det_ready = ($urandom_range(0, 9) == 0) ? N_CH'($urandom) : '1;
            if ($urandom_range(0, 7) == 0) ch_enable = N_CH'($urandom);
            delay_cycles = CNT_W'($urandom_range(0, 12));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
